move_cursor: RTL and testbench

Button-driven move entry for the Go board. Replaces the temporary switch-based move source feeding the game FSM's `move` input. Keeps a wrapping cursor over the board from debounced direction buttons and issues a committed 8-bit move with a one-cycle `move_avail` strobe when the player selects or passes on their turn. `cursor_row`/`cursor_col` also go to the display for cursor highlighting.

---
 rtl/move_cursor.sv | 174 +++++++++++++++++
 tb/tb_move_cursor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_cursor.sv
`default_nettype none
// ============================================================================
// Module   : move_cursor
// Purpose  : Wrapping board cursor driven by direction buttons; commits a
//            move or pass as an 8-bit code with a one-cycle strobe.
//            Auto-repeat on held directions when MOVE_CURSOR_AUTO_REPEAT_EN
//            is defined.
// Revision : 1.0
// ============================================================================
module move_cursor #(
  parameter int         BOARD_SIZE    = 9,
  parameter int         REPEAT_DELAY  = 32_500_000,
  parameter int         REPEAT_PERIOD = 6_500_000,
  parameter logic [7:0] PASS_CODE     = 8'hFF
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       btn_pass,
  input  logic       enable,
  output logic [7:0] move_out,
  output logic       move_avail,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col
);

  localparam logic [3:0] c_LAST = 4'(BOARD_SIZE - 1);
  localparam logic [3:0] c_MID  = 4'(BOARD_SIZE / 2);

  // bit order: {pass, sel, right, left, down, up}
  logic [5:0] r_sample;
  logic [5:0] r_prev;
  logic [5:0] w_edge;
  logic [3:0] w_step;
  logic [3:0] r_row;
  logic [3:0] r_col;
  logic [3:0] w_row_next;
  logic [3:0] w_col_next;
  logic [7:0] r_move;
  logic       r_avail;
  logic       w_sel;
  logic       w_pass;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_sample <= '0;
      r_prev   <= '0;
    end else begin
      r_sample <= {btn_pass, btn_sel, btn_right, btn_left, btn_down, btn_up};
      r_prev   <= r_sample;
    end
  end

  assign w_edge = r_sample & ~r_prev;

`ifdef MOVE_CURSOR_AUTO_REPEAT_EN
  localparam int                 c_CNT_W       = $clog2(REPEAT_DELAY + 1);
  localparam logic [c_CNT_W-1:0] c_DELAY_LAST  = c_CNT_W'(REPEAT_DELAY - 1);
  localparam logic [c_CNT_W-1:0] c_PERIOD_LAST = c_CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX     = {c_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_cnt_clr;
  logic [3:0]         w_held;

  assign w_held = r_sample[3:0];

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_cnt != c_CNT_MAX)
        r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // A fresh press always wins: step only the new directions and restart the delay.
  always_comb begin
    w_state_next = r_state;
    w_step       = 4'b0000;
    w_cnt_clr    = 1'b0;
    if (|w_edge[3:0]) begin
      w_step       = w_edge[3:0];
      w_cnt_clr    = 1'b1;
      w_state_next = ST_DELAY;
    end else begin
      case (r_state)
        ST_DELAY: begin
          if (~|w_held) begin
            w_state_next = ST_IDLE;
          end else if (r_cnt == c_DELAY_LAST) begin
            w_step       = w_held;
            w_cnt_clr    = 1'b1;
            w_state_next = ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          if (~|w_held) begin
            w_state_next = ST_IDLE;
          end else if (r_cnt == c_PERIOD_LAST) begin
            w_step    = w_held;
            w_cnt_clr = 1'b1;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end
`else
  // A zero timing parameter is a configuration error; directions then stay inert.
  if (REPEAT_DELAY > 0 && REPEAT_PERIOD > 0) begin : g_edge_step
    assign w_step = w_edge[3:0];
  end else begin : g_no_step
    assign w_step = 4'b0000;
  end
`endif

  always_comb begin
    w_row_next = r_row;
    w_col_next = r_col;
    if (w_step[0] && !w_step[1])
      w_row_next = (r_row == 4'd0) ? c_LAST : r_row - 4'd1;
    else if (w_step[1] && !w_step[0])
      w_row_next = (r_row == c_LAST) ? 4'd0 : r_row + 4'd1;
    if (w_step[2] && !w_step[3])
      w_col_next = (r_col == 4'd0) ? c_LAST : r_col - 4'd1;
    else if (w_step[3] && !w_step[2])
      w_col_next = (r_col == c_LAST) ? 4'd0 : r_col + 4'd1;
  end

  assign w_sel  = w_edge[4] & enable;
  assign w_pass = w_edge[5] & enable;

  // Committed position is the cursor before any step taken in the same cycle.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_row   <= c_MID;
      r_col   <= c_MID;
      r_move  <= 8'h00;
      r_avail <= 1'b0;
    end else begin
      r_row   <= w_row_next;
      r_col   <= w_col_next;
      r_avail <= w_sel | w_pass;
      if (w_sel)
        r_move <= {r_row, r_col};
      else if (w_pass)
        r_move <= PASS_CODE;
    end
  end

  assign move_out   = r_move;
  assign move_avail = r_avail;
  assign cursor_row = r_row;
  assign cursor_col = r_col;

endmodule
`default_nettype wire

// File: tb/tb_move_cursor.sv
`default_nettype none
// Scoreboard bench for move_cursor: directed presses push expected cursor
// positions / committed moves with their arrival cycle; a monitor checks them.
module tb_move_cursor;

  localparam logic [5:0] U = 6'd1, D = 6'd2, L = 6'd4, R = 6'd8, S = 6'd16, P = 6'd32;

  logic       clk_in   = 1'b0;
  logic       rst_in_n = 1'b0;
  logic       btn_up, btn_down, btn_left, btn_right, btn_sel, btn_pass;
  logic       enable   = 1'b0;
  logic [7:0] move_out;
  logic       move_avail;
  logic [3:0] cursor_row;
  logic [3:0] cursor_col;

  always #5 clk_in = ~clk_in;

  move_cursor #(
    .BOARD_SIZE   (9),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(4),
    .PASS_CODE    (8'hFF)
  ) dut (
    .clk_in    (clk_in),
    .rst_in_n  (rst_in_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_sel   (btn_sel),
    .btn_pass  (btn_pass),
    .enable    (enable),
    .move_out  (move_out),
    .move_avail(move_avail),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col)
  );

  typedef struct { logic [7:0] pos; int t; } cur_t;
  typedef struct { logic [7:0] v;   int t; } mv_t;

  cur_t cur_q[$];
  mv_t  mv_q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_btn(input logic [5:0] m);
    {btn_pass, btn_sel, btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  task automatic push_cur(input logic [7:0] pos, input int t);
    cur_t e;
    e.pos = pos;
    e.t   = t;
    cur_q.push_back(e);
  endtask

  task automatic push_mv(input logic [7:0] v, input int t);
    mv_t e;
    e.v = v;
    e.t = t;
    mv_q.push_back(e);
  endtask

  // One-cycle press; results are due at the negedge two cycles after the drive.
  task automatic press(input logic [5:0] m, input bit cur_ch, input logic [7:0] pos,
                       input bit mv_ch, input logic [7:0] v);
    @(negedge clk_in);
    set_btn(m);
    if (cur_ch) push_cur(pos, cyc + 2);
    if (mv_ch)  push_mv(v, cyc + 2);
    @(negedge clk_in);
    set_btn(6'd0);
    repeat (3) @(negedge clk_in);
  endtask

  // Monitor: every cursor change and every move_avail cycle must match the queue head.
  initial begin
    logic [7:0] pos;
    logic [7:0] last_pos;
    cur_t       ec;
    mv_t        em;
    last_pos = 8'h44;
    forever begin
      @(negedge clk_in);
      pos = {cursor_row, cursor_col};
      if (!rst_in_n) begin
        last_pos = pos;
      end else begin
        if (pos !== last_pos) begin
          if (cur_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_step: got %0h, expected %0h (cycle %0d)", pos, last_pos, cyc);
          end else begin
            ec = cur_q.pop_front();
            check("cursor_pos", 32'(pos), 32'(ec.pos));
            check("cursor_cycle", cyc, ec.t);
          end
          last_pos = pos;
        end
        if (move_avail !== 1'b0) begin
          if (mv_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_avail: got move_avail=%b move_out=%0h, expected no strobe (cycle %0d)",
                     move_avail, move_out, cyc);
          end else begin
            em = mv_q.pop_front();
            check("move_out", 32'(move_out), 32'(em.v));
            check("move_cycle", cyc, em.t);
          end
        end
      end
    end
  end

  initial begin
    int t;
    set_btn(6'd0);
    repeat (3) @(negedge clk_in);
    check("rst_row", 32'(cursor_row), 32'd4);
    check("rst_col", 32'(cursor_col), 32'd4);
    check("rst_move", 32'(move_out), 32'h00);
    check("rst_avail", 32'(move_avail), 32'd0);
    rst_in_n = 1'b1;

    // Column wrap 4 -> 8 -> 0
    press(R, 1, 8'h45, 0, 8'h00);
    press(R, 1, 8'h46, 0, 8'h00);
    press(R, 1, 8'h47, 0, 8'h00);
    press(R, 1, 8'h48, 0, 8'h00);
    press(R, 1, 8'h40, 0, 8'h00);
    check("col_wrap", 32'(cursor_col), 32'd0);

    press(U, 1, 8'h30, 0, 8'h00);
    press(U, 1, 8'h20, 0, 8'h00);
    press(U, 1, 8'h10, 0, 8'h00);
    press(U, 1, 8'h00, 0, 8'h00);
    press(R, 1, 8'h01, 0, 8'h00);
    press(R, 1, 8'h02, 0, 8'h00);
    press(R, 1, 8'h03, 0, 8'h00);
    press(U, 1, 8'h83, 0, 8'h00);
    press(U | D, 0, 8'h00, 0, 8'h00);
    check("up_down_cancel", 32'({cursor_row, cursor_col}), 32'h83);
    press(U | L, 1, 8'h72, 0, 8'h00);

    // Diagonal walk to (2,6), with row wrap 8 -> 0
    press(D | R, 1, 8'h83, 0, 8'h00);
    press(D | R, 1, 8'h04, 0, 8'h00);
    press(D | R, 1, 8'h15, 0, 8'h00);
    press(D | R, 1, 8'h26, 0, 8'h00);

    enable = 1'b1;
    press(S, 0, 8'h00, 1, 8'h26);
    press(S | R, 1, 8'h27, 1, 8'h26);
    press(L, 1, 8'h26, 0, 8'h00);

    enable = 1'b0;
    press(S, 0, 8'h00, 0, 8'h00);
    press(P, 0, 8'h00, 0, 8'h00);
    check("disabled_hold", 32'(move_out), 32'h26);

    enable = 1'b1;
    press(S | P, 0, 8'h00, 1, 8'h26);
    press(P, 0, 8'h00, 1, 8'hFF);

    // Hold down from row 0; sampled high for 31 consecutive edges
    press(U, 1, 8'h16, 0, 8'h00);
    press(U, 1, 8'h06, 0, 8'h00);
    @(negedge clk_in);
    set_btn(D);
    t = cyc + 2;
`ifdef MOVE_CURSOR_AUTO_REPEAT_EN
    push_cur(8'h16, t);
    push_cur(8'h26, t + 10);
    push_cur(8'h36, t + 14);
    push_cur(8'h46, t + 18);
    push_cur(8'h56, t + 22);
    push_cur(8'h66, t + 26);
    push_cur(8'h76, t + 30);
`else
    push_cur(8'h16, t);
`endif
    repeat (31) @(negedge clk_in);
    set_btn(6'd0);
    repeat (6) @(negedge clk_in);
`ifdef MOVE_CURSOR_AUTO_REPEAT_EN
    check("hold_final_row", 32'(cursor_row), 32'd7);
`else
    check("hold_final_row", 32'(cursor_row), 32'd1);
`endif

    // Hold right into repeat, then async reset between edges
    @(negedge clk_in);
    set_btn(R);
    t = cyc + 2;
`ifdef MOVE_CURSOR_AUTO_REPEAT_EN
    push_cur(8'h77, t);
    push_cur(8'h78, t + 10);
`else
    push_cur(8'h17, t);
`endif
    repeat (14) @(negedge clk_in);
    @(posedge clk_in);
    #2 rst_in_n = 1'b0;
    #1;
    check("async_rst_row", 32'(cursor_row), 32'd4);
    check("async_rst_col", 32'(cursor_col), 32'd4);
    check("async_rst_move", 32'(move_out), 32'h00);
    check("async_rst_avail", 32'(move_avail), 32'd0);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    push_cur(8'h45, cyc + 2);
    @(negedge clk_in);
    set_btn(6'd0);
    repeat (20) @(negedge clk_in);

    check("cur_q_drained", 32'(cur_q.size()), 32'd0);
    check("mv_q_drained", 32'(mv_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
